// File: rtl/lim_mem_req_ctrl_if.sv
// lim_mem_req_ctrl_if: bundles the core-side request/response handshake and
// the mem_datapath control/result signals of lim_mem_req_ctrl.
//   slave  : the request controller (takes core requests, drives datapath)
//   master : the environment (core issuing requests + datapath answering)
// Core side  : data_req_i/data_gnt_o, request fields, data_rvalid_o/rdata/err
// Datapath   : mem_en_ab_o strobe, held operand fields, mem_rdata_i/mem_rvalid_i
interface lim_mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [31:0]           data_addr_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [31:0]           data_wdata_i;
    logic [7:0]            data_funct_i;
    logic [31:0]           data_mask_i;
    logic                  data_rvalid_o;
    logic [31:0]           data_rdata_o;
    logic                  data_err_o;

    logic                  mem_en_ab_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [3:0]            mem_be_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_we_o;
    logic [31:0]           mem_mask_o;
    logic [7:0]            mem_funct_o;
    logic [31:0]           mem_rdata_i;
    logic                  mem_rvalid_i;

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               data_funct_i, data_mask_i, mem_rdata_i, mem_rvalid_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
               mem_en_ab_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o,
               mem_mask_o, mem_funct_o
    );

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               data_funct_i, data_mask_i, mem_rdata_i, mem_rvalid_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
               mem_en_ab_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o,
               mem_mask_o, mem_funct_o
    );
endinterface

// File: rtl/lim_mem_req_ctrl.sv
// lim_mem_req_ctrl: request sequencer in front of the racetrack LiM datapath.
// Core requests are captured into a one-entry buffer, popped into an active
// register that drives the datapath operands, launched with a single-cycle
// en_ab strobe and completed on the rising edge of the datapath's level
// r_valid (or by timeout). Out-of-range addresses bypass the datapath and
// answer with an error. Responses are strictly in order.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous reset, active high
//   bus    - lim_mem_req_ctrl_if.slave (core handshake + datapath signals)
module lim_mem_req_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int MAX_SIZE       = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    lim_mem_req_ctrl_if.slave bus
);
    localparam logic [7:0] FUNCT_NONE = 8'h00;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [7:0]            funct;
        logic [31:0]           mask;
    } req_t;

    state_t     state_q, state_d;
    req_t       buf_q, act_q;
    logic       buf_valid_q, buf_oor_q;
    logic [CNT_W-1:0] cnt_q;
    logic       rvalid_q;
    logic [31:0] resp_data_q, resp_data_d;
    logic       resp_err_q, resp_err_d;
    logic       gnt, pop, cnt_clr, cnt_inc, resp_ld, rvalid_rise;

    // Reset also masks the grant so nothing is accepted while rst_i is high.
    assign gnt         = bus.data_req_i & ~buf_valid_q & ~rst_i;
    assign rvalid_rise = bus.mem_rvalid_i & ~rvalid_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        resp_ld     = 1'b0;
        resp_err_d  = 1'b0;
        resp_data_d = '0;
        case (state_q)
            // RESP shares the pop decision with IDLE so a buffered request
            // launches without an idle bubble.
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (buf_valid_q) begin
                    pop = 1'b1;
                    if (buf_oor_q) begin
                        state_d    = ST_RESP;
                        resp_ld    = 1'b1;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion edge in the last allowed cycle still wins.
                if (rvalid_rise) begin
                    state_d     = ST_RESP;
                    resp_ld     = 1'b1;
                    resp_data_d = bus.mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    resp_ld    = 1'b1;
                    resp_err_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture and pop never coincide: grant requires an empty buffer, pop a full one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            buf_oor_q   <= 1'b0;
            buf_q       <= '0;
        end else if (gnt) begin
            buf_valid_q <= 1'b1;
            buf_oor_q   <= {1'b0, bus.data_addr_i} >= 33'(MAX_SIZE);
            buf_q.addr  <= bus.data_addr_i[ADDR_WIDTH-1:0];
            buf_q.we    <= bus.data_we_i;
            buf_q.be    <= bus.data_be_i;
            buf_q.wdata <= bus.data_wdata_i;
            buf_q.funct <= bus.data_funct_i;
            buf_q.mask  <= bus.data_mask_i;
        end else if (pop) begin
            buf_valid_q <= 1'b0;
        end
    end

    // Out-of-range pops leave the datapath operands untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q       <= '0;
            act_q.funct <= FUNCT_NONE;
        end else if (pop && !buf_oor_q) begin
            act_q <= buf_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rvalid_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            rvalid_q <= bus.mem_rvalid_i;
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (resp_ld) begin
                resp_data_q <= resp_data_d;
                resp_err_q  <= resp_err_d;
            end
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = (state_q == ST_RESP);
    assign bus.data_rdata_o  = (state_q == ST_RESP) ? resp_data_q : '0;
    assign bus.data_err_o    = (state_q == ST_RESP) & resp_err_q;

    assign bus.mem_en_ab_o = (state_q == ST_ISSUE);
    assign bus.mem_addr_o  = act_q.addr;
    assign bus.mem_be_o    = act_q.be;
    assign bus.mem_wdata_o = act_q.wdata;
    assign bus.mem_we_o    = act_q.we;
    assign bus.mem_mask_o  = act_q.mask;
    assign bus.mem_funct_o = act_q.funct;
endmodule

// File: tb/tb_lim_mem_req_ctrl.sv
module tb_lim_mem_req_ctrl;
    localparam int AW = 8;
    localparam int MS = 256;
    localparam int TO = 16;
    localparam logic [7:0] FUNCT_NONE = 8'h00;
    localparam logic [7:0] FUNCT_NOR  = 8'h06;
    localparam int NEVER = 0;   // datapath never completes

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  funct;
        logic [31:0] mask;
        int          lat;    // cycles from en_ab to r_valid rise, NEVER = none
        logic [31:0] data;   // what the datapath returns
    } req_t;
    typedef struct { logic err; logic [31:0] data; int due; } exp_t;
    typedef struct { req_t r; int due_en; } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   abort_wait = 1'b0;
    exp_t exp_q[$];
    iss_t iss_q[$];

    lim_mem_req_ctrl_if #(.ADDR_WIDTH(AW)) bus();

    lim_mem_req_ctrl #(.ADDR_WIDTH(AW), .MAX_SIZE(MS), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] mem_fields();
        return 128'({bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o,
                     bus.mem_funct_o, bus.mem_mask_o});
    endfunction

    function automatic logic [127:0] req_fields(input req_t r);
        logic [AW-1:0] a;
        a = r.addr[AW-1:0];
        return 128'({a, r.we, r.be, r.wdata, r.funct, r.mask});
    endfunction

    function automatic req_t mk(input logic [31:0] addr, input logic we, input logic [7:0] funct,
                                input logic [31:0] mask, input int lat, input logic [31:0] data);
        req_t r;
        r.addr = addr; r.we = we; r.be = 4'hF; r.wdata = $urandom;
        r.funct = funct; r.mask = mask; r.lat = lat; r.data = data;
        return r;
    endfunction

    // Issue one request, wait for its grant and record what the core must see.
    task automatic send(input req_t r, input int gap);
        int  w;
        bit  idle, oor;
        exp_t e;
        iss_t s;
        @(negedge clk);
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = r.addr;
        bus.data_we_i    = r.we;
        bus.data_be_i    = r.be;
        bus.data_wdata_i = r.wdata;
        bus.data_funct_i = r.funct;
        bus.data_mask_i  = r.mask;
        w = 0;
        #1;
        while (!bus.data_gnt_o && w < 300) begin
            @(negedge clk); #1; w++;
        end
        if (!bus.data_gnt_o) begin
            n_chk++; n_fail++;
            $display("FAIL grant_wait: got no grant expected grant within 300 cycles");
            bus.data_req_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        n_chk++;
        if (exp_q.size() >= 2) begin
            n_fail++;
            $display("FAIL outstanding: got %0d expected at most 1 before grant", exp_q.size());
        end
        idle = (exp_q.size() == 0);
        oor  = (r.addr >= 32'(MS));
        if (oor) begin
            e.err = 1'b1; e.data = '0; e.due = idle ? cyc + 1 : -1;
        end else if (r.lat == NEVER) begin
            e.err = 1'b1; e.data = '0; e.due = idle ? cyc + TO + 2 : -1;
        end else begin
            e.err = 1'b0; e.data = r.data; e.due = idle ? cyc + r.lat + 2 : -1;
        end
        exp_q.push_back(e);
        if (!oor) begin
            s.r = r; s.due_en = idle ? cyc + 1 : -1;
            iss_q.push_back(s);
        end
        if (gap > 0) begin
            bus.data_req_i = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk); w++;
        end
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.data_rvalid_o) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got response data %0h expected none", bus.data_rdata_o);
            end else begin
                e = exp_q.pop_front();
                check("resp_err", 128'(bus.data_err_o), 128'(e.err));
                check("resp_data", 128'(bus.data_rdata_o), 128'(e.data));
                if (e.due >= 0) check("resp_cycle", 128'(cyc), 128'(e.due));
            end
        end
    end

    // Datapath model: answers each en_ab after the planned latency and checks
    // the operands stay put while it works.
    initial begin
        iss_t s;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_en_ab_o) begin
                abort_wait = 1'b0;
                if (iss_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_en_ab: got en_ab expected none at cycle %0d", cyc);
                end else begin
                    s = iss_q.pop_front();
                    check("issue_fields", mem_fields(), req_fields(s.r));
                    if (s.due_en >= 0) check("issue_cycle", 128'(cyc), 128'(s.due_en));
                    repeat ((s.r.lat == NEVER) ? TO : s.r.lat - 1) begin
                        @(negedge clk);
                        if (!rst && !abort_wait) begin
                            check("hold_fields", mem_fields(), req_fields(s.r));
                            check("hold_en_ab", 128'(bus.mem_en_ab_o), 128'(0));
                        end
                    end
                    if (s.r.lat != NEVER) begin
                        @(negedge clk);
                        bus.mem_rvalid_i = 1'b1;
                        bus.mem_rdata_i  = s.r.data;
                        @(negedge clk);
                        bus.mem_rvalid_i = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        req_t r;
        int   w;
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h4;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'h0;
        bus.data_wdata_i = '0;
        bus.data_funct_i = FUNCT_NONE;
        bus.data_mask_i  = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_gnt", 128'(bus.data_gnt_o), 128'(0));
        check("rst_rvalid", 128'({bus.data_rvalid_o, bus.data_err_o, bus.data_rdata_o}), 128'(0));
        check("rst_en_ab", 128'(bus.mem_en_ab_o), 128'(0));
        check("rst_mem", mem_fields(), 128'(0));
        bus.data_req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single store, then LiM NOR load
        r = mk(32'h04, 1'b1, FUNCT_NONE, 32'h0, 7, $urandom);
        r.wdata = 32'h349B;
        send(r, 1); drain();
        send(mk(32'h08, 1'b0, FUNCT_NOR, 32'hF1, 5, 32'hFFFF9600), 1); drain();
        // three requests with req held high throughout
        send(mk(32'h00, 1'b1, FUNCT_NONE, 32'h0, 4, $urandom), 0);
        send(mk(32'h04, 1'b0, FUNCT_NONE, 32'h0, 3, $urandom), 0);
        send(mk(32'h0C, 1'b0, FUNCT_NOR, 32'h5A, 2, $urandom), 1);
        drain();
        // range boundaries
        send(mk(32'h100, 1'b0, FUNCT_NONE, 32'h0, 3, $urandom), 1); drain();
        send(mk(32'hFF, 1'b0, FUNCT_NONE, 32'h0, 1, $urandom), 1); drain();
        send(mk(32'hFFFF_FFFF, 1'b1, FUNCT_NONE, 32'h0, 3, $urandom), 1); drain();
        // timeout, then a request completing on the last allowed cycle
        send(mk(32'h10, 1'b0, FUNCT_NONE, 32'h0, NEVER, $urandom), 1); drain();
        send(mk(32'h14, 1'b0, FUNCT_NONE, 32'h0, TO, $urandom), 1); drain();

        for (int i = 0; i < 40; i++) begin
            r = mk(($urandom_range(0, 5) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, MS - 1)),
                   1'($urandom), ($urandom_range(0, 2) == 0) ? FUNCT_NONE : 8'($urandom),
                   $urandom, ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(1, TO), $urandom);
            r.be = 4'($urandom);
            send(r, $urandom_range(0, 3));
        end
        bus.data_req_i = 1'b0;
        drain();

        // reset while waiting on the datapath; its late completion must be dropped
        send(mk(32'h20, 1'b0, FUNCT_NONE, 32'h0, 10, $urandom), 1);
        w = 0;
        do begin
            @(negedge clk); w++;
        end while (!bus.mem_en_ab_o && w < 20);
        check("rt_en_ab_seen", 128'(bus.mem_en_ab_o), 128'(1));
        repeat (3) @(negedge clk);
        #2;
        bus.data_req_i = 1'b1;
        abort_wait = 1'b1;
        rst = 1'b1;
        #1;
        check("rt_en_ab", 128'(bus.mem_en_ab_o), 128'(0));
        check("rt_rvalid", 128'(bus.data_rvalid_o), 128'(0));
        check("rt_gnt", 128'(bus.data_gnt_o), 128'(0));
        check("rt_mem", mem_fields(), 128'(0));
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        bus.data_req_i = 1'b0;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        send(mk(32'h24, 1'b0, FUNCT_NOR, 32'h3C, 3, $urandom), 1); drain();

        check("queues_empty", 128'(exp_q.size() + iss_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test expected finish before 500000");
        $fatal(1, "simulation time limit");
    end
endmodule
